// File: rtl/weight_buffer_loader.sv
// Weight buffer loader: steers a column-major weight stream into per-column FIFOs.
// The stream is throttled on the current column's full flag, and done pulses once per tile.
module weight_buffer_loader #(
   parameter int unsigned SYS_COLS   = 4,
   parameter int unsigned W_BITWIDTH = 8,
   parameter int unsigned ROW_W      = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [ROW_W-1:0]                     num_rows,
   input  logic                                 s_valid,
   input  logic [W_BITWIDTH-1:0]                s_data,
   output logic                                 s_ready,
   input  logic [SYS_COLS-1:0]                  col_full,
   output logic [SYS_COLS-1:0]                  wr_en,
   output logic [SYS_COLS-1:0][W_BITWIDTH-1:0]  o_data,
   output logic                                 busy,
   output logic                                 done
);

   localparam int unsigned COL_W = (SYS_COLS > 1) ? $clog2(SYS_COLS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e                                state_q, state_d;
   logic [ROW_W-1:0]                      rows_q, rows_d;
   logic [ROW_W-1:0]                      row_cnt_q, row_cnt_d;
   logic [COL_W-1:0]                      col_idx_q, col_idx_d;
   logic [SYS_COLS-1:0]                   wr_en_q, wr_en_d;
   logic [SYS_COLS-1:0][W_BITWIDTH-1:0]   o_data_q, o_data_d;
   logic                                  done_q, done_d;
   logic                                  busy_q, busy_d;

   logic                                  ready_c;
   logic                                  accept_c;
   logic                                  last_row_c;
   logic                                  last_col_c;

   // Handshake: ready depends only on state and the current column's full flag.
   always_comb begin
      ready_c    = (state_q == ST_LOAD) && !col_full[col_idx_q];
      accept_c   = s_valid && ready_c;
      last_row_c = (row_cnt_q == ROW_W'(rows_q - ROW_W'(1)));
      last_col_c = (col_idx_q == COL_W'(SYS_COLS - 1));
   end

   // Next-state, counters and registered write-side outputs.
   always_comb begin
      state_d   = state_q;
      rows_d    = rows_q;
      row_cnt_d = row_cnt_q;
      col_idx_d = col_idx_q;
      wr_en_d   = '0;
      o_data_d  = o_data_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rows_d    = num_rows;
               row_cnt_d = '0;
               col_idx_d = '0;
               state_d   = (num_rows == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (accept_c) begin
               wr_en_d             = SYS_COLS'(1) << col_idx_q;
               o_data_d[col_idx_q] = s_data;
               if (last_row_c) begin
                  row_cnt_d = '0;
                  if (last_col_c) begin
                     col_idx_d = '0;
                     state_d   = ST_DONE;
                  end else begin
                     col_idx_d = COL_W'(col_idx_q + COL_W'(1));
                  end
               end else begin
                  row_cnt_d = ROW_W'(row_cnt_q + ROW_W'(1));
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      done_d = (state_d == ST_DONE);
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rows_q    <= '0;
         row_cnt_q <= '0;
         col_idx_q <= '0;
         wr_en_q   <= '0;
         o_data_q  <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rows_q    <= rows_d;
         row_cnt_q <= row_cnt_d;
         col_idx_q <= col_idx_d;
         wr_en_q   <= wr_en_d;
         o_data_q  <= o_data_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   assign s_ready = ready_c;
   assign wr_en   = wr_en_q;
   assign o_data  = o_data_q;
   assign done    = done_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Scoreboard bench for weight_buffer_loader: accepted beats are queued, then matched to FIFO writes.
module tb_weight_buffer_loader;

   localparam int unsigned SYS_COLS   = 4;
   localparam int unsigned W_BITWIDTH = 8;
   localparam int unsigned ROW_W      = 8;

   typedef struct packed {
      logic [31:0]           col;
      logic [W_BITWIDTH-1:0] data;
      logic                  last;
   } exp_t;

   logic                                 clk;
   logic                                 rst;
   logic                                 start;
   logic [ROW_W-1:0]                     num_rows;
   logic                                 s_valid;
   logic [W_BITWIDTH-1:0]                s_data;
   logic                                 s_ready;
   logic [SYS_COLS-1:0]                  col_full;
   logic [SYS_COLS-1:0]                  wr_en;
   logic [SYS_COLS-1:0][W_BITWIDTH-1:0]  o_data;
   logic                                 busy;
   logic                                 done;

   exp_t q[$];
   int   n_tests   = 0;
   int   n_fail    = 0;
   int   cyc       = 0;
   int   done_cnt  = 0;
   int   done_cyc  = 0;
   int   lone_done = 0;

   weight_buffer_loader #(
      .SYS_COLS  (SYS_COLS),
      .W_BITWIDTH(W_BITWIDTH),
      .ROW_W     (ROW_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .num_rows(num_rows),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_ready (s_ready),
      .col_full(col_full),
      .wr_en   (wr_en),
      .o_data  (o_data),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Write monitor: every write must match the oldest accepted beat.
   always @(negedge clk) begin
      exp_t e;
      logic [SYS_COLS-1:0] ew;
      if (wr_en != '0) begin
         if (q.size() == 0) begin
            chk("wr_unexpected", 32'(wr_en), 32'(0));
         end else begin
            e  = q.pop_front();
            ew = SYS_COLS'(1) << e.col;
            chk("wr_en", 32'(wr_en), 32'(ew));
            chk("o_data", 32'(o_data[e.col[1:0]]), 32'(e.data));
            chk("done_with_last", 32'(done), 32'(e.last));
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         if (wr_en == '0) lone_done++;
         chk("busy_in_done", 32'(busy), 32'(1));
      end
   end

   // Runs one tile. vmode 1 toggles s_valid; stall_after/len/col hold a column full;
   // abort_after stops driving after that many accepts; restart re-pulses start mid-load.
   task automatic run_tile(input int rows, input int vmode, input int stall_after,
                           input int stall_len, input int stall_col, input int abort_after,
                           input bit restart, input int exp_lat);
      int total, beat, s, dbefore, stall_rem, it;
      bit stall_used, got_done;
      total      = rows * int'(SYS_COLS);
      beat       = 0;
      stall_rem  = 0;
      stall_used = 1'b0;
      got_done   = 1'b0;
      dbefore    = done_cnt;
      @(negedge clk);
      start    = 1'b1;
      num_rows = ROW_W'(rows);
      s_valid  = 1'b0;
      s        = cyc;
      @(negedge clk);
      start    = 1'b0;
      num_rows = ROW_W'($urandom_range(0, 255));
      for (it = 0; it < 300; it++) begin
         s_valid = (vmode == 1) ? (it % 2 == 0) : 1'b1;
         s_data  = W_BITWIDTH'(beat + 1);
         start   = restart && (beat == 5);
         if (stall_after >= 0 && beat == stall_after && !stall_used) begin
            stall_rem  = stall_len;
            stall_used = 1'b1;
         end
         col_full = (stall_rem > 0) ? SYS_COLS'(SYS_COLS'(1) << stall_col) : '0;
         #2;
         if (stall_rem > 0) begin
            chk("ready_during_stall", 32'(s_ready), 32'(0));
            stall_rem--;
         end
         if (s_valid && s_ready) begin
            q.push_back('{col: 32'(beat / rows), data: s_data, last: (beat == total - 1)});
            beat++;
         end
         if (total == 0) chk("ready_zero_rows", 32'(s_ready), 32'(0));
         if (beat == total || beat == abort_after) break;
         @(negedge clk);
      end
      @(negedge clk);
      s_valid  = 1'b0;
      start    = 1'b0;
      col_full = '0;
      if (abort_after >= 0) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         #1;
         chk("rst_wr_en", 32'(wr_en), 32'(0));
         chk("rst_o_data", o_data, 32'(0));
         chk("rst_busy", 32'(busy), 32'(0));
         chk("rst_ready", 32'(s_ready), 32'(0));
         chk("rst_queue_empty", 32'(q.size()), 32'(0));
         return;
      end
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clk);
         #3;
         if (done_cnt > dbefore) begin
            got_done = 1'b1;
            break;
         end
      end
      chk("done_seen", 32'(got_done), 32'(1));
      if (got_done) chk("done_latency", 32'(done_cyc - s), 32'(exp_lat));
      @(negedge clk);
      #1;
      chk("busy_after_done", 32'(busy), 32'(0));
      chk("ready_after_done", 32'(s_ready), 32'(0));
      repeat (3) @(negedge clk);
      #1;
      chk("single_done", 32'(done_cnt - dbefore), 32'(1));
      chk("beats_accepted", 32'(beat), 32'(total));
      chk("queue_drained", 32'(q.size()), 32'(0));
   endtask

   initial begin
      int ld;
      rst      = 1'b1;
      start    = 1'b0;
      num_rows = '0;
      s_valid  = 1'b0;
      s_data   = '0;
      col_full = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_wr_en", 32'(wr_en), 32'(0));
      chk("reset_o_data", o_data, 32'(0));
      chk("reset_busy", 32'(busy), 32'(0));
      chk("reset_done", 32'(done), 32'(0));
      chk("reset_ready", 32'(s_ready), 32'(0));
      rst = 1'b0;

      // Plain 4x3 tile.
      run_tile(3, 0, -1, 0, 0, -1, 1'b0, 13);
      chk("final_o_data", o_data, 32'h0C09_0603);

      // Column 1 held full for 5 cycles after the 4th accept.
      run_tile(3, 0, 4, 5, 1, -1, 1'b0, 18);
      chk("stall_final_o_data", o_data, 32'h0C09_0603);

      // Bubbles on s_valid.
      run_tile(2, 1, -1, 0, 0, -1, 1'b0, 16);
      chk("bubble_final_o_data", o_data, 32'h0806_0402);

      // Empty tile: done without writes.
      ld = lone_done;
      run_tile(0, 0, -1, 0, 0, -1, 1'b0, 1);
      chk("zero_rows_lone_done", 32'(lone_done - ld), 32'(1));

      // Reset after 5 accepts, then a one-row tile.
      run_tile(3, 0, -1, 0, 0, 5, 1'b0, 0);
      run_tile(1, 0, -1, 0, 0, -1, 1'b0, 5);
      chk("post_reset_o_data", o_data, 32'h0403_0201);

      // start re-pulsed during LOAD is ignored.
      ld = lone_done;
      run_tile(3, 0, -1, 0, 0, -1, 1'b1, 13);
      chk("restart_no_lone_done", 32'(lone_done - ld), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
